id_ex_pipe_reg: RTL and testbench
=================================

// Module: id_ex_pipe_reg
// PURPOSE
//  ID/EX pipeline register: captures the decode stage's operands, immediate, PC and control bundles, and presents them to EX.
//  Implements stall (hold), flush (bubble insert) and halt squashing of younger instructions.
//  Keeps a saturating count of bubble cycles for the performance counters.
// PARAMETERS
//  DW      16  datapath width (regA/regB data, imm, pc)
//  RW      4   register-address width
//  CNT_W   16  bubble-counter width
// PORTS
//  clk           in   1      rising-edge clock
//  rst           in   1      synchronous reset, active-high
//  stall         in   1      hazard unit: hold all stage contents
//  flush         in   1      branch taken: replace contents with bubble
//  id_valid      in   1      ID holds a real instruction this cycle
//  id_pc         in   DW     PC (pcD) from ID
//  id_rs_data    in   DW     regAData from ID
//  id_rt_data    in   DW     regBData from ID
//  id_imm        in   DW     sign/zero-extended immediate from ID
//  id_rs, id_rt  in   RW     source register numbers (for forwarding)
//  id_rd         in   RW     destination register number
//  id_ex_ctl     in   6      {aluSrc, regDst, opcode[3:0]}
//  id_mem_ctl    in   3      {memRead, memWrite, memHalf}
//  id_wb_ctl     in   2      {memToReg, regWrite}
//  id_halt       in   1      decoded HLT
//  ex_*          out  same   registered copies of every id_* input above (incl. ex_valid, ex_halt)
//  halted        out  1      sticky: a valid HLT has entered EX
//  bubble_cnt    out  CNT_W  saturating count of cycles with ex_valid==0 after reset
// BEHAVIOUR
//  Reset (rst=1 at posedge): all ex_* outputs 0, halted=0, bubble_cnt=0. Reset overrides all other inputs.
//  Per-edge priority: rst > flush > stall > halted-squash > load.
//   flush: ex_valid, ex_ex_ctl, ex_mem_ctl, ex_wb_ctl, ex_halt <= 0.
//    Data fields (pc, data, imm, reg numbers) <= 0. Clears halted.
//   stall (no flush): every ex_* register holds its value; halted holds.
//   halted=1 (no flush/stall): load a bubble (same as flush) but keep halted=1.
//   otherwise load: every ex_* <= corresponding id_*.
//    If id_valid=0, load the bubble instead, so a bubble never carries a nonzero control bit.
//  halted <= 1 on the edge where a load captures id_valid=1 and id_halt=1.
//  Latency: exactly 1 cycle from ID to EX when not stalled.
//  bubble_cnt: increments on each edge where the post-edge ex_valid is 0. Stall cycles holding a bubble also count.
//   bubble_cnt saturates at all-ones; it never wraps.
//  Simultaneous stall+flush: flush wins. The hazard unit must not rely on stall to preserve a wrong-path instruction.
//  Invariant: ex_valid=0 implies ex_mem_ctl=0 and ex_wb_ctl[0]=0 (no memory or register side effects).
//  No combinational path from any input to any output.
// STRUCTURE
//  Shared package/include (cpu_defs): field widths and bundle bit positions.
//   EX: ALUSRC_B=5, REGDST_B=4, OPC=[3:0]. MEM: MRD_B=2, MWR_B=1, MHALF_B=0. WB: M2R_B=1, RWR_B=0.
//   Also the BUBBLE constants (all-zero bundles).
//  One natural sub-module: pipe_field_reg #(W) with rst/clear/hold/d/q, instantiated once per field.
//  Priority logic and halted/bubble_cnt live in the top module.
// TESTING
//  1 Reset mid-run: load valid ADD, then rst=1 for 1 cycle -> all ex_* = 0, halted=0, bubble_cnt=0 next cycle.
//  2 Load: id_pc=16'h0010, id_rs_data=16'h1234, id_wb_ctl=2'b01, id_valid=1 ->
//     ex_pc=16'h0010, ex_rs_data=16'h1234, ex_wb_ctl=2'b01 one cycle later.
//  3 Stall 3 cycles holding a LW (id_mem_ctl=3'b100) while ID inputs change -> ex_* unchanged for 3 cycles.
//     Release -> new values appear after 1 edge.
//  4 stall=1 and flush=1 same edge with valid SW in EX -> ex_valid=0, ex_mem_ctl=0, bubble_cnt +1.
//  5 HLT (id_halt=1, id_valid=1) loaded -> halted=1.
//     Subsequent valid IDs give ex_valid=0. A flush then clears halted and the next load passes.
//  6 Hold id_valid=0 for 2^CNT_W+5 cycles (CNT_W overridden to 4) -> bubble_cnt stops at 4'hF, never 0.

Source files
------------

// File: rtl/id_ex_pipe_reg_pkg.sv
// id_ex_pipe_reg_pkg: ID/EX bundle widths, bit positions and bubble constants
package id_ex_pipe_reg_pkg;
  localparam int EX_W = 6;
  localparam int MEM_W = 3;
  localparam int WB_W = 2;
  localparam int ALUSRC_B = 5;
  localparam int REGDST_B = 4;
  localparam int OPC_HI = 3;
  localparam int OPC_LO = 0;
  localparam int MRD_B = 2;
  localparam int MWR_B = 1;
  localparam int MHALF_B = 0;
  localparam int M2R_B = 1;
  localparam int RWR_B = 0;
  localparam logic [EX_W-1:0] EX_BUBBLE = '0;
  localparam logic [MEM_W-1:0] MEM_BUBBLE = '0;
  localparam logic [WB_W-1:0] WB_BUBBLE = '0;
endpackage

// File: rtl/id_ex_pipe_reg_field.sv
// pipe_field_reg: one pipeline field with clear-to-zero (over hold) and hold
module pipe_field_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         hold,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] q_d, q_q;
  always_comb q_d = clear ? '0 : hold ? q_q : d;
  always_ff @(posedge clk)
    if (rst) q_q <= '0;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with stall, flush, halt squash and bubble counting
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [DW-1:0]    id_pc,
  input  logic [DW-1:0]    id_rs_data,
  input  logic [DW-1:0]    id_rt_data,
  input  logic [DW-1:0]    id_imm,
  input  logic [RW-1:0]    id_rs,
  input  logic [RW-1:0]    id_rt,
  input  logic [RW-1:0]    id_rd,
  input  logic [EX_W-1:0]  id_ex_ctl,
  input  logic [MEM_W-1:0] id_mem_ctl,
  input  logic [WB_W-1:0]  id_wb_ctl,
  input  logic             id_halt,
  output logic             ex_valid,
  output logic [DW-1:0]    ex_pc,
  output logic [DW-1:0]    ex_rs_data,
  output logic [DW-1:0]    ex_rt_data,
  output logic [DW-1:0]    ex_imm,
  output logic [RW-1:0]    ex_rs,
  output logic [RW-1:0]    ex_rt,
  output logic [RW-1:0]    ex_rd,
  output logic [EX_W-1:0]  ex_ex_ctl,
  output logic [MEM_W-1:0] ex_mem_ctl,
  output logic [WB_W-1:0]  ex_wb_ctl,
  output logic             ex_halt,
  output logic             halted,
  output logic [CNT_W-1:0] bubble_cnt
);
  logic clear, valid_nx, halted_d, halted_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  // Invalid IDs and post-halt instructions load as an all-zero bubble
  always_comb begin
    clear = flush | (~stall & (halted_q | ~id_valid));
    valid_nx = flush ? 1'b0 : stall ? ex_valid : id_valid & ~halted_q;
    halted_d = flush ? 1'b0 : stall ? halted_q : halted_q | (id_valid & id_halt);
    cnt_d = (~valid_nx && ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      halted_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      halted_q <= halted_d;
      cnt_q <= cnt_d;
    end
  assign halted = halted_q;
  assign bubble_cnt = cnt_q;
  pipe_field_reg #(1)     u_valid (.clk, .rst, .clear, .hold(stall), .d(id_valid),   .q(ex_valid));
  pipe_field_reg #(DW)    u_pc    (.clk, .rst, .clear, .hold(stall), .d(id_pc),      .q(ex_pc));
  pipe_field_reg #(DW)    u_rsd   (.clk, .rst, .clear, .hold(stall), .d(id_rs_data), .q(ex_rs_data));
  pipe_field_reg #(DW)    u_rtd   (.clk, .rst, .clear, .hold(stall), .d(id_rt_data), .q(ex_rt_data));
  pipe_field_reg #(DW)    u_imm   (.clk, .rst, .clear, .hold(stall), .d(id_imm),     .q(ex_imm));
  pipe_field_reg #(RW)    u_rs    (.clk, .rst, .clear, .hold(stall), .d(id_rs),      .q(ex_rs));
  pipe_field_reg #(RW)    u_rt    (.clk, .rst, .clear, .hold(stall), .d(id_rt),      .q(ex_rt));
  pipe_field_reg #(RW)    u_rd    (.clk, .rst, .clear, .hold(stall), .d(id_rd),      .q(ex_rd));
  pipe_field_reg #(EX_W)  u_exc   (.clk, .rst, .clear, .hold(stall), .d(id_ex_ctl),  .q(ex_ex_ctl));
  pipe_field_reg #(MEM_W) u_memc  (.clk, .rst, .clear, .hold(stall), .d(id_mem_ctl), .q(ex_mem_ctl));
  pipe_field_reg #(WB_W)  u_wbc   (.clk, .rst, .clear, .hold(stall), .d(id_wb_ctl),  .q(ex_wb_ctl));
  pipe_field_reg #(1)     u_halt  (.clk, .rst, .clear, .hold(stall), .d(id_halt),    .q(ex_halt));
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: directed vectors checked against a bundle-level model every cycle
module tb_id_ex_pipe_reg;
  import id_ex_pipe_reg_pkg::*;
  typedef struct packed {
    logic valid;
    logic [15:0] pc, rs_data, rt_data, imm;
    logic [3:0] rs, rt, rd;
    logic [5:0] ex_ctl;
    logic [2:0] mem_ctl;
    logic [1:0] wb_ctl;
    logic halt;
  } bun_t;
  logic clk = 0, rst = 1, stall = 0, flush = 0;
  bun_t in = '0, m = '0, act;
  logic mh = 0;
  logic [3:0] mc = 0;
  logic halted;
  logic [3:0] bubble_cnt;
  int checks = 0, errors = 0;
  id_ex_pipe_reg #(.DW(16), .RW(4), .CNT_W(4)) dut (
    .clk, .rst, .stall, .flush,
    .id_valid(in.valid), .id_pc(in.pc), .id_rs_data(in.rs_data), .id_rt_data(in.rt_data),
    .id_imm(in.imm), .id_rs(in.rs), .id_rt(in.rt), .id_rd(in.rd),
    .id_ex_ctl(in.ex_ctl), .id_mem_ctl(in.mem_ctl), .id_wb_ctl(in.wb_ctl), .id_halt(in.halt),
    .ex_valid(act.valid), .ex_pc(act.pc), .ex_rs_data(act.rs_data), .ex_rt_data(act.rt_data),
    .ex_imm(act.imm), .ex_rs(act.rs), .ex_rt(act.rt), .ex_rd(act.rd),
    .ex_ex_ctl(act.ex_ctl), .ex_mem_ctl(act.mem_ctl), .ex_wb_ctl(act.wb_ctl), .ex_halt(act.halt),
    .halted, .bubble_cnt
  );
  always #5 clk = ~clk;
  function automatic bun_t nxt_m();
    if (rst || flush) return '0;
    if (stall) return m;
    if (mh || !in.valid) return '0;
    return in;
  endfunction
  function automatic logic nxt_h();
    if (rst || flush) return 1'b0;
    if (stall) return mh;
    return mh | (in.valid & in.halt);
  endfunction
  function automatic logic [3:0] nxt_c();
    bun_t n;
    n = nxt_m();
    if (rst) return 4'h0;
    return (!n.valid && mc != 4'hF) ? mc + 4'h1 : mc;
  endfunction
  always @(posedge clk) begin
    m <= nxt_m();
    mh <= nxt_h();
    mc <= nxt_c();
  end
  always @(negedge clk) begin
    checks++;
    if ({act, halted, bubble_cnt} !== {m, mh, mc}) begin
      errors++;
      $display("FAIL model t=%0t got %h/%b/%h want %h/%b/%h", $time, act, halted, bubble_cnt, m, mh, mc);
    end
  end
  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", name, a, e);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    cyc();
    rst = 0;
    in = '0; in.valid = 1; in.pc = 16'h0004; in.rd = 4'd3; in.ex_ctl = 6'h01; in.wb_ctl = 2'b01;
    cyc();
    chk("add_loaded", act.valid, 1);
    rst = 1;
    cyc();
    rst = 0;
    chk("rst_valid", act.valid, 0);
    chk("rst_pc", act.pc, 0);
    chk("rst_wb", act.wb_ctl, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cnt", bubble_cnt, 0);
    in = '0; in.valid = 1; in.pc = 16'h0010; in.rs_data = 16'h1234; in.wb_ctl = 2'b01;
    cyc();
    chk("ld_pc", act.pc, 16'h0010);
    chk("ld_rsd", act.rs_data, 16'h1234);
    chk("ld_wb", act.wb_ctl, 2'b01);
    in = '0; in.valid = 1; in.pc = 16'h0020; in.rt = 4'd5; in.imm = 16'h0008;
    in.mem_ctl = 3'b100; in.wb_ctl = 2'b11; in.ex_ctl = 6'h20;
    cyc();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      in.pc = 16'h0030 + 16'(i); in.mem_ctl = 3'b010; in.imm = 16'hBEEF;
      cyc();
      chk("stall_pc", act.pc, 16'h0020);
      chk("stall_mem", act.mem_ctl, 3'b100);
    end
    stall = 0;
    in = '0; in.valid = 1; in.pc = 16'h0040; in.rs_data = 16'h00AA;
    cyc();
    chk("release_pc", act.pc, 16'h0040);
    chk("release_mem", act.mem_ctl, 0);
    in = '0; in.valid = 1; in.pc = 16'h0044; in.mem_ctl = 3'b010; in.rt_data = 16'h5555;
    cyc();
    chk("sw_mem", act.mem_ctl, 3'b010);
    stall = 1; flush = 1;
    cyc();
    stall = 0; flush = 0;
    chk("sf_valid", act.valid, 0);
    chk("sf_mem", act.mem_ctl, MEM_BUBBLE);
    chk("sf_cnt", bubble_cnt, 1);
    in = '0; in.valid = 1; in.halt = 1; in.pc = 16'h0048;
    cyc();
    chk("hlt_halted", halted, 1);
    chk("hlt_exhalt", act.halt, 1);
    in = '0; in.valid = 1; in.pc = 16'h004C; in.wb_ctl = 2'b01;
    cyc();
    chk("squash_valid", act.valid, 0);
    chk("squash_wb", act.wb_ctl, WB_BUBBLE);
    chk("squash_halted", halted, 1);
    chk("squash_cnt", bubble_cnt, 2);
    flush = 1;
    cyc();
    flush = 0;
    chk("flush_halted", halted, 0);
    in.pc = 16'h0050;
    cyc();
    chk("post_valid", act.valid, 1);
    chk("post_pc", act.pc, 16'h0050);
    chk("post_cnt", bubble_cnt, 3);
    rst = 1;
    cyc();
    rst = 0;
    in = '0;
    for (int i = 1; i <= 21; i++) begin
      cyc();
      if (i == 14) chk("sat_e", bubble_cnt, 4'hE);
      if (i == 15) chk("sat_f", bubble_cnt, 4'hF);
    end
    chk("sat_hold", bubble_cnt, 4'hF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
